// File: rtl/alu_pkg.sv
// Shared constants for the PA_1 ALU: datapath width and Funct encodings.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] FUNCT_ADD  = 6'b000000;
    localparam logic [5:0] FUNCT_SUB  = 6'b000010;
    localparam logic [5:0] FUNCT_AND  = 6'b000100;
    localparam logic [5:0] FUNCT_OR   = 6'b000101;
    localparam logic [5:0] FUNCT_XOR  = 6'b000110;
    localparam logic [5:0] FUNCT_NOR  = 6'b000111;
    localparam logic [5:0] FUNCT_SLT  = 6'b001010;
    localparam logic [5:0] FUNCT_SLTU = 6'b001011;
    localparam logic [5:0] FUNCT_SLL  = 6'b010000;
    localparam logic [5:0] FUNCT_SRL  = 6'b010010;
    localparam logic [5:0] FUNCT_SRA  = 6'b010011;
    localparam logic [5:0] FUNCT_ROTR = 6'b010100;

endpackage

// File: rtl/alu_adder.sv
// 32-bit adder with carry-in; the 33rd sum bit is the carry-out.
module alu_adder
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};

endmodule

// File: rtl/alu.sv
// Registered-output 32-bit ALU: one shared adder, inline logic/shift units,
// result and carry loaded every rising clk edge.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Src1,
    input  logic [DATA_W-1:0] Src2,
    input  logic [5:0]        Funct,
    output logic [DATA_W-1:0] ALU_result,
    output logic              ALU_Carry
);

    logic              is_add;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W:0]   add_sum;
    logic              sub_ovf;
    logic              lt_signed;
    logic              lt_unsigned;
    logic [4:0]        shamt;
    logic [4:0]        rot_left;
    logic [DATA_W-1:0] rotr_val;
    logic [DATA_W-1:0] next_result;
    logic              next_carry;

    // ADD uses b=Src2, cin=0; SUB and both compares reuse the subtract path.
    assign is_add = (Funct == FUNCT_ADD);
    assign add_b  = is_add ? Src2 : ~Src2;

    alu_adder u_adder (
        .a   (Src1),
        .b   (add_b),
        .cin (~is_add),
        .sum (add_sum)
    );

    // Signed less-than is the difference sign corrected by overflow;
    // unsigned less-than is a borrow, i.e. no carry out of the subtract.
    assign sub_ovf     = (Src1[DATA_W-1] != Src2[DATA_W-1]) &&
                         (add_sum[DATA_W-1] != Src1[DATA_W-1]);
    assign lt_signed   = add_sum[DATA_W-1] ^ sub_ovf;
    assign lt_unsigned = ~add_sum[DATA_W];

    assign shamt    = Src2[4:0];
    assign rot_left = 5'd0 - shamt;
    assign rotr_val = (Src1 >> shamt) | (Src1 << rot_left);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        next_result = '0;
        next_carry  = 1'b0;
        case (Funct)
            FUNCT_ADD, FUNCT_SUB: begin
                next_result = add_sum[DATA_W-1:0];
                next_carry  = add_sum[DATA_W];
            end
            FUNCT_AND:  next_result = Src1 & Src2;
            FUNCT_OR:   next_result = Src1 | Src2;
            FUNCT_XOR:  next_result = Src1 ^ Src2;
            FUNCT_NOR:  next_result = ~(Src1 | Src2);
            FUNCT_SLT:  next_result = {{(DATA_W-1){1'b0}}, lt_signed};
            FUNCT_SLTU: next_result = {{(DATA_W-1){1'b0}}, lt_unsigned};
            FUNCT_SLL:  next_result = Src1 << shamt;
            FUNCT_SRL:  next_result = Src1 >> shamt;
            FUNCT_SRA:  next_result = $unsigned($signed(Src1) >>> shamt);
            FUNCT_ROTR: next_result = rotr_val;
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments for registered state; the synchronous
    // reset overrides compute, so outputs are clean even with X inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_result <= '0;
            ALU_Carry  <= 1'b0;
        end else begin
            ALU_result <= next_result;
            ALU_Carry  <= next_carry;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for alu with hand-computed expected values.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic [5:0]  Funct;
    logic [31:0] ALU_result;
    logic        ALU_Carry;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] exp_res;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .Src1       (Src1),
        .Src2       (Src2),
        .Funct      (Funct),
        .ALU_result (ALU_result),
        .ALU_Carry  (ALU_Carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r, input logic c);
        vec_t v;
        v.name = n; v.funct = f; v.src1 = a; v.src2 = b; v.exp_res = r; v.exp_carry = c;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        Funct = f;
        Src1  = a;
        Src2  = b;
    endtask

    initial begin
        add_vec("add_small",   FUNCT_ADD,  32'h00000010, 32'h00000020, 32'h00000030, 1'b0);
        add_vec("add_wrap",    FUNCT_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        add_vec("sub_borrow",  FUNCT_SUB,  32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        add_vec("sub_noborr",  FUNCT_SUB,  32'h00001800, 32'h00000200, 32'h00001600, 1'b1);
        add_vec("sub_equal",   FUNCT_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
        add_vec("and",         FUNCT_AND,  32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 1'b0);
        add_vec("or",          FUNCT_OR,   32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 1'b0);
        add_vec("xor",         FUNCT_XOR,  32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1'b0);
        add_vec("nor",         FUNCT_NOR,  32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0);
        add_vec("slt_neg",     FUNCT_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        add_vec("sltu_big",    FUNCT_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        add_vec("slt_pos",     FUNCT_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        add_vec("slt_ovf",     FUNCT_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        add_vec("sltu_small",  FUNCT_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        add_vec("slt_equal",   FUNCT_SLT,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
        add_vec("sra_neg",     FUNCT_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
        add_vec("sra_pos",     FUNCT_SRA,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0);
        add_vec("srl",         FUNCT_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
        add_vec("sll_31",      FUNCT_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0);
        add_vec("sll_amt21",   FUNCT_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0);
        add_vec("rotr_1",      FUNCT_ROTR, 32'h00000001, 32'h00000001, 32'h80000000, 1'b0);
        add_vec("rotr_8",      FUNCT_ROTR, 32'h12345678, 32'h00000008, 32'h78123456, 1'b0);
        add_vec("rotr_0",      FUNCT_ROTR, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0);
        add_vec("srl_0",       FUNCT_SRL,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0);
        add_vec("illegal_3f",  6'b111111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        add_vec("illegal_01",  6'b000001,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);

        // Reset held for two edges with random inputs.
        rst = 1'b1;
        drive(FUNCT_ADD, $urandom, $urandom);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_result", ALU_result, 32'h0);
            check("rst_carry", {31'b0, ALU_Carry}, 32'h0);
            drive(FUNCT_SUB, $urandom, $urandom);
        end

        // First edge after release shows the computed value.
        rst = 1'b0;
        drive(FUNCT_ADD, 32'hFFFFFFFF, 32'h00000002);
        @(posedge clk); #1;
        check("release_result", ALU_result, 32'h00000001);
        check("release_carry", {31'b0, ALU_Carry}, 32'h1);

        // Back-to-back table: a new op every cycle, each result one edge later.
        foreach (vecs[i]) begin
            drive(vecs[i].funct, vecs[i].src1, vecs[i].src2);
            @(posedge clk); #1;
            check({vecs[i].name, "_res"}, ALU_result, vecs[i].exp_res);
            check({vecs[i].name, "_carry"}, {31'b0, ALU_Carry}, {31'b0, vecs[i].exp_carry});
        end

        // Inputs changing between edges must not disturb the registered outputs.
        drive(FUNCT_OR, 32'h00000F00, 32'h000000F0);
        @(posedge clk); #1;
        drive(FUNCT_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #3;
        check("hold_result", ALU_result, 32'h00000FF0);
        check("hold_carry", {31'b0, ALU_Carry}, 32'h0);
        @(posedge clk); #1;
        check("after_hold_result", ALU_result, 32'hFFFFFFFE);
        check("after_hold_carry", {31'b0, ALU_Carry}, 32'h1);

        // Reset mid-stream wins over a compute that would set carry.
        rst = 1'b1;
        drive(FUNCT_ADD, 32'hFFFFFFFF, 32'h00000001);
        @(posedge clk); #1;
        check("midrst_result", ALU_result, 32'h0);
        check("midrst_carry", {31'b0, ALU_Carry}, 32'h0);
        rst = 1'b0;
        drive(FUNCT_XOR, 32'hAAAAAAAA, 32'hFFFFFFFF);
        @(posedge clk); #1;
        check("post_rst_result", ALU_result, 32'h55555555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
